// File: rtl/req_ack_pkg.sv
// Shared definitions for the request/acknowledge responder.
//   resp_state_t : head-of-queue state (IDLE / WAIT / PRESENT)
//   LAT_W        : width of latency configuration and per-entry countdown
//   clamp_lat    : limits a requested latency to the range [lo, hi]
package req_ack_pkg;

    localparam int LAT_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        PRESENT = 2'd2
    } resp_state_t;

    function automatic logic [LAT_W-1:0] clamp_lat(
        input logic [LAT_W-1:0] lat,
        input logic [LAT_W-1:0] lo,
        input logic [LAT_W-1:0] hi
    );
        if (lat < lo) begin
            return lo;
        end else if (lat > hi) begin
            return hi;
        end else begin
            return lat;
        end
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// Request queue with a per-entry latency countdown.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   i_push            : write i_push_data / i_push_cnt at the tail
//   i_push_data       : payload stored with the entry
//   i_push_cnt        : countdown loaded into the new entry
//   i_pop             : retire the head entry
//   o_count           : number of stored entries
//   o_count_next      : entry count after the current edge
//   o_head_data       : payload of the head entry
//   o_head_cnt        : countdown of the head entry
//   o_head_cnt_next   : countdown of the entry that will be head after the edge
// The caller guarantees no push when full and no pop when empty.
module resp_fifo
    import req_ack_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [DW-1:0]              i_push_data,
    input  logic [LAT_W-1:0]           i_push_cnt,
    input  logic                       i_pop,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [$clog2(DEPTH):0]     o_count_next,
    output logic [DW-1:0]              o_head_data,
    output logic [LAT_W-1:0]           o_head_cnt,
    output logic [LAT_W-1:0]           o_head_cnt_next
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0]                 r_mem [DEPTH];
    logic [DEPTH-1:0][LAT_W-1:0]   r_cnt;
    logic [DEPTH-1:0][LAT_W-1:0]   w_cnt_next;
    logic [PW-1:0]                 r_wr_ptr;
    logic [PW-1:0]                 r_rd_ptr;
    logic [PW-1:0]                 w_rd_ptr_next;
    logic [CW-1:0]                 r_count;

    // Every slot counts down in parallel; the slot being written takes the
    // fresh load value instead. Stale slots simply sit at zero.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cnt
        assign w_cnt_next[gi] = (i_push && (r_wr_ptr == PW'(gi))) ? i_push_cnt :
                                (r_cnt[gi] != '0) ? r_cnt[gi] - 1'b1 : '0;
    end

    assign w_rd_ptr_next   = r_rd_ptr + PW'(i_pop);
    assign o_count_next    = r_count + CW'(i_push) - CW'(i_pop);
    assign o_count         = r_count;
    assign o_head_data     = r_mem[r_rd_ptr];
    assign o_head_cnt      = r_cnt[r_rd_ptr];
    assign o_head_cnt_next = w_cnt_next[w_rd_ptr_next];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_wr_ptr <= r_wr_ptr + PW'(i_push);
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= o_count_next;
        end
    end

    // Payload storage needs no reset: it is only visible while an entry is valid.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/req_ack_responder.sv
// Request/acknowledge target. Each accepted request is acknowledged in
// accept order after a per-request latency clamped to [MIN_LAT, MAX_LAT].
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   req_valid     : request present
//   req_data      : request payload
//   req_ready     : queue has space (pending < DEPTH)
//   lat_cfg       : requested latency, captured at accept
//   ack_valid     : head entry has expired and is offered
//   ack_data      : payload of the offered entry (0 when not valid)
//   ack_ready     : consumer takes the ack
//   pending       : outstanding request count
//   busy          : pending != 0
//   err_overflow  : sticky, set by a request while full
module req_ack_responder
    import req_ack_pkg::*;
#(
    parameter int DW      = 8,
    parameter int DEPTH   = 4,
    parameter int MIN_LAT = 1,
    parameter int MAX_LAT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic [DW-1:0]          req_data,
    output logic                   req_ready,
    input  logic [LAT_W-1:0]       lat_cfg,
    output logic                   ack_valid,
    output logic [DW-1:0]          ack_data,
    input  logic                   ack_ready,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   busy,
    output logic                   err_overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [LAT_W-1:0] w_lat;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count;
    logic [CW-1:0]    w_count_next;
    logic [DW-1:0]    w_head_data;
    logic [LAT_W-1:0] w_head_cnt;
    logic [LAT_W-1:0] w_head_cnt_next;
    logic             r_err;
    resp_state_t      r_state;
    resp_state_t      w_state_next;

    assign w_lat  = clamp_lat(lat_cfg, LAT_W'(MIN_LAT), LAT_W'(MAX_LAT));
    assign w_push = req_valid && req_ready;
    assign w_pop  = ack_valid && ack_ready;

    resp_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk             (clk),
        .rst             (rst),
        .i_push          (w_push),
        .i_push_data     (req_data),
        .i_push_cnt      (w_lat - 1'b1),
        .i_pop           (w_pop),
        .o_count         (w_count),
        .o_count_next    (w_count_next),
        .o_head_data     (w_head_data),
        .o_head_cnt      (w_head_cnt),
        .o_head_cnt_next (w_head_cnt_next)
    );

    // Full is judged on the current count only: a pop in the same cycle
    // does not open a slot for the incoming request.
    assign req_ready    = (w_count != CW'(DEPTH));
    assign ack_valid    = (w_count != '0) && (w_head_cnt == '0);
    assign ack_data     = ack_valid ? w_head_data : '0;
    assign pending      = w_count;
    assign busy         = (w_count != '0);
    assign err_overflow = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (req_valid && !req_ready) begin
            r_err <= 1'b1;
        end
    end

    // Head tracker; mirrors what the queue head is doing for observation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_push) begin
                    w_state_next = (w_lat == LAT_W'(1)) ? PRESENT : WAIT;
                end
            end
            WAIT: begin
                if (w_head_cnt_next == '0) begin
                    w_state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (w_pop) begin
                    if (w_count_next == '0) begin
                        w_state_next = IDLE;
                    end else if (w_head_cnt_next == '0) begin
                        w_state_next = PRESENT;
                    end else begin
                        w_state_next = WAIT;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_req_ack_responder.sv
module tb_req_ack_responder;

    localparam int DW      = 8;
    localparam int DEPTH   = 4;
    localparam int MIN_LAT = 1;
    localparam int MAX_LAT = 4;
    localparam int CW      = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic [DW-1:0] req_data;
    logic          req_ready;
    logic [2:0]    lat_cfg;
    logic          ack_valid;
    logic [DW-1:0] ack_data;
    logic          ack_ready;
    logic [CW-1:0] pending;
    logic          busy;
    logic          err_overflow;

    req_ack_responder #(
        .DW(DW), .DEPTH(DEPTH), .MIN_LAT(MIN_LAT), .MAX_LAT(MAX_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .lat_cfg      (lat_cfg),
        .ack_valid    (ack_valid),
        .ack_data     (ack_data),
        .ack_ready    (ack_ready),
        .pending      (pending),
        .busy         (busy),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        int            rdy;   // first edge at which the ack may be sampled
    } exp_t;

    exp_t sb[$];
    logic m_ovf = 1'b0;

    function automatic int eff_lat(input int l);
        if (l < MIN_LAT) return MIN_LAT;
        if (l > MAX_LAT) return MAX_LAT;
        return l;
    endfunction

    // Scoreboard: at each falling edge, compare against what the next rising
    // edge will sample, then apply that edge's accept/ack to the model.
    always @(negedge clk) begin
        if (rst) begin
            check_val("rst_req_ready", 32'(req_ready), 32'd1);
            check_val("rst_ack_valid", 32'(ack_valid), 32'd0);
            check_val("rst_ack_data", 32'(ack_data), 32'd0);
            check_val("rst_pending", 32'(pending), 32'd0);
            check_val("rst_busy", 32'(busy), 32'd0);
            check_val("rst_err_overflow", 32'(err_overflow), 32'd0);
            sb.delete();
            m_ovf = 1'b0;
        end else begin
            automatic int  edge_n = cyc + 1;
            automatic bit  exp_v  = (sb.size() != 0) && (sb[0].rdy <= edge_n);
            automatic bit  full   = (sb.size() >= DEPTH);
            check_val("ack_valid", 32'(ack_valid), 32'(exp_v));
            if (exp_v) check_val("ack_data", 32'(ack_data), 32'(sb[0].data));
            check_val("pending", 32'(pending), 32'(sb.size()));
            check_val("busy", 32'(busy), 32'(sb.size() != 0));
            check_val("req_ready", 32'(req_ready), 32'(!full));
            check_val("err_overflow", 32'(err_overflow), 32'(m_ovf));
            if (exp_v && ack_ready) begin
                $display("ACK    edge=%0d data=%02h", edge_n, sb[0].data);
                void'(sb.pop_front());
            end
            if (req_valid) begin
                if (!full) begin
                    exp_t e;
                    e.data = req_data;
                    e.rdy  = edge_n + eff_lat(int'(lat_cfg));
                    sb.push_back(e);
                    $display("ACCEPT edge=%0d data=%02h lat_cfg=%0d", edge_n, req_data, lat_cfg);
                end else begin
                    m_ovf = 1'b1;
                    $display("DROP   edge=%0d data=%02h", edge_n, req_data);
                end
            end
        end
    end

    // Apply inputs for one rising edge; returns 1 time unit after that edge.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [2:0] l, input logic a);
        req_valid = v;
        req_data  = d;
        lat_cfg   = l;
        ack_ready = a;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic a);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 3'd0, a);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_data = '0; lat_cfg = '0; ack_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(5, 1'b1);

        // Single request, latency 3: ack visible for exactly one cycle.
        drive(1'b1, 8'hA5, 3'd3, 1'b1);
        drive(1'b0, 8'h00, 3'd0, 1'b1);
        check_val("t1_not_yet", 32'(ack_valid), 32'd0);
        drive(1'b0, 8'h00, 3'd0, 1'b1);
        check_val("t1_ack_valid", 32'(ack_valid), 32'd1);
        check_val("t1_ack_data", 32'(ack_data), 32'hA5);
        drive(1'b0, 8'h00, 3'd0, 1'b1);
        check_val("t1_ack_gone", 32'(ack_valid), 32'd0);
        check_val("t1_pending", 32'(pending), 32'd0);
        idle(2, 1'b1);

        // Latency clamping at both ends.
        drive(1'b1, 8'h11, 3'd0, 1'b1);
        drive(1'b1, 8'h22, 3'd7, 1'b1);
        idle(6, 1'b1);

        // Long head followed by short entries: order preserved, back-to-back.
        drive(1'b1, 8'h01, 3'd4, 1'b1);
        drive(1'b1, 8'h02, 3'd1, 1'b1);
        drive(1'b1, 8'h03, 3'd1, 1'b1);
        drive(1'b1, 8'h04, 3'd1, 1'b1);
        idle(8, 1'b1);

        // Backpressure: ack held stable while ack_ready is low.
        drive(1'b1, 8'h3C, 3'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'h00, 3'd0, 1'b0);
            check_val("t4_stall_valid", 32'(ack_valid), 32'd1);
            check_val("t4_stall_data", 32'(ack_data), 32'h3C);
        end
        drive(1'b0, 8'h00, 3'd0, 1'b1);
        check_val("t4_done_pending", 32'(pending), 32'd0);
        idle(2, 1'b1);

        // Fill, overflow, drain: error flag persists.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(8'h50 + i), 3'd1, 1'b0);
        check_val("t5_full_ready", 32'(req_ready), 32'd0);
        drive(1'b1, 8'hEE, 3'd1, 1'b0);
        check_val("t5_ovf", 32'(err_overflow), 32'd1);
        check_val("t5_full_pending", 32'(pending), 32'd4);
        idle(6, 1'b1);
        check_val("t5_ovf_sticky", 32'(err_overflow), 32'd1);
        check_val("t5_drained", 32'(pending), 32'd0);

        // Asynchronous reset with entries outstanding.
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h70 + i), 3'd4, 1'b0);
        check_val("t6_pre_pending", 32'(pending), 32'd3);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_val("t6_async_pending", 32'(pending), 32'd0);
        check_val("t6_async_ready", 32'(req_ready), 32'd1);
        check_val("t6_async_busy", 32'(busy), 32'd0);
        check_val("t6_async_ovf", 32'(err_overflow), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(8, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
        end
        idle(12, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/req_ack_responder.md
Name: req_ack_responder

Overview:
- Request/acknowledge target that answers each accepted request with an in-order acknowledge after a per-request programmable latency.
- Sits directly upstream of the concurrent-assertion bench. Its req_valid/ack_valid pair is the stimulus/response that the bounded-delay property "req |-> ##[1:4] ack" checks.
- Buffers up to DEPTH outstanding requests, returns the request payload with the acknowledge, and flags dropped requests.

Parameters:
- DW, 8, request/ack payload width
- DEPTH, 4, max outstanding requests (power of 2, >=2)
- MIN_LAT, 1, minimum ack latency in cycles (>=1)
- MAX_LAT, 4, maximum ack latency in cycles (<=7)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_data  in  DW  request payload
- req_ready  out  1  space available; high when count < DEPTH
- lat_cfg  in  3  requested latency, sampled at accept
- ack_valid  out  1  acknowledge present
- ack_data  out  DW  payload of the acknowledged request
- ack_ready  in  1  consumer takes the ack
- pending  out  $clog2(DEPTH)+1  outstanding request count
- busy  out  1  pending != 0
- err_overflow  out  1  sticky; set when req_valid && !req_ready

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high. While rst is high, all outputs are 0 except req_ready, which is 1. Queue flushed; err_overflow cleared.
- Reset mid-operation: pending requests are discarded and never acknowledged. The first edge after rst deasserts behaves as from empty.
- Accept:
  - A request is accepted at edge N when req_valid && req_ready.
  - Effective latency L = clamp(lat_cfg, MIN_LAT, MAX_LAT). lat_cfg=0 gives MIN_LAT; lat_cfg>MAX_LAT gives MAX_LAT.
  - L is captured per entry at accept. Later lat_cfg changes do not affect stored entries.
- Entry storage: each entry holds data plus a countdown loaded with L-1. All non-zero countdowns decrement every cycle, independent of ack_ready, and saturate at 0.
- Ack timing:
  - ack_valid = (pending != 0) && head countdown == 0.
  - With an idle queue and ack_ready=1, ack_valid is sampled high at exactly edge N+L.
  - ack_valid rises only after the corresponding accept.
- Ordering: acks are strictly in accept order. A younger entry whose countdown has expired waits behind the head. A shorter latency never overtakes a longer one.
- Ack handshake: the ack completes at an edge where ack_valid && ack_ready.
  - While ack_valid && !ack_ready, ack_valid stays high and ack_data stays stable.
  - Back-to-back acks (one per cycle) are allowed when the following entries have already expired.
- Simultaneous accept and ack completion in one cycle: pending is unchanged and the pointers advance independently.
- Full:
  - req_ready is 0 when pending == DEPTH; no same-cycle pass-through on pop.
  - A req_valid while full is dropped and sets err_overflow, which holds until rst.
- Pointers wrap modulo DEPTH. pending has one extra bit to tell full from empty.
- Head FSM (state exported for observability in simulation only):
  - IDLE: pending == 0. Goes to WAIT on accept with L>1, or to PRESENT on accept with L=1.
  - WAIT: head countdown > 0. Goes to PRESENT when the countdown reaches 0.
  - PRESENT: ack_valid high. On ack handshake goes to PRESENT if the next entry's countdown is 0, to WAIT if it is >0, or to IDLE if no entry remains.

Decomposition:
- Package req_ack_pkg:
  - resp_state_t enum {IDLE, WAIT, PRESENT}
  - LAT_W = 3
  - function clamp_lat(lat, min, max)
- Sub-module resp_fifo: DEPTH x (DW+LAT_W) storage with wrapping pointers, per-entry parallel countdown, and head view.
- Top module: accept logic, clamp, FSM, overflow flag.

Test Plan:
- Single request, data=8'hA5, lat_cfg=3, ack_ready=1 accepted at edge 10 -> ack_valid sampled high at edge 13 only, ack_data=8'hA5, pending returns to 0 at edge 14.
- lat_cfg=0 then lat_cfg=7 -> effective latencies 1 and 4. Every accept satisfies req |-> ##[1:4] ack; the assertion never fails.
- Four requests 8'h01..8'h04 with lat_cfg 4,1,1,1 on consecutive edges -> acks in order 01,02,03,04 on four consecutive cycles starting 4 edges after the first accept.
- ack_ready held 0 for 5 cycles with ack_valid high, data=8'h3C -> ack_valid and ack_data stable all 5 cycles. The handshake completes on the first edge with ack_ready=1.
- Fill to DEPTH=4 with ack_ready=0, then a fifth req_valid -> req_ready=0, request dropped, err_overflow=1 persists after the queue drains.
- rst pulsed while pending=3 -> outputs zero immediately (asynchronous), req_ready=1, no stale ack after release.
